// File: rtl/prime_collector_if.sv
// Candidate stream from primenums plus the show-ahead FIFO read port.
// Latency: none, this is wiring only.
// Backpressure: none on the candidate side; the reader pops with RdReq while RdValid is 1.
//
// Signals:
//   NumberChecked [9:0]  current candidate from primenums
//   Prime                primality flag for NumberChecked
//   RdReq                pop request from the downstream reader
//   RdData [9:0]         FIFO head value, 0 when empty
//   RdValid              FIFO holds at least one entry
// master = generator/reader side, slave = collector side.
interface prime_collector_if;
   logic [9:0] NumberChecked;
   logic       Prime;
   logic       RdReq;
   logic [9:0] RdData;
   logic       RdValid;

   modport master (
      output NumberChecked, Prime, RdReq,
      input  RdData, RdValid
   );

   modport slave (
      input  NumberChecked, Prime, RdReq,
      output RdData, RdValid
   );
endinterface

// File: rtl/prime_collector.sv
// Watches the primenums candidate stream and queues every prime into a show-ahead FIFO.
// Latency: a new candidate is sampled SETTLE edges after it is detected; push results are visible after that edge.
// Backpressure: none upstream; a prime that finds the FIFO full (and no pop on the same edge) is dropped and Overflow sticks.
//
// Ports:
//   SysClk, Reset (async, active low)
//   NumMax [9:0]          last candidate of the run
//   bus (slave)           candidate stream in, FIFO read port out
//   Count                 entries held, 0..DEPTH
//   Total [7:0]           primes observed since reset, saturating
//   Overflow              sticky drop indicator
//   Done                  the final candidate has been sampled
module prime_collector #(
   parameter int DEPTH  = 32,
   parameter int SETTLE = 2
) (
   input  logic                         SysClk,
   input  logic                         Reset,
   input  logic [9:0]                   NumMax,
   prime_collector_if.slave             bus,
   output logic [$clog2(DEPTH+1)-1:0]   Count,
   output logic [7:0]                   Total,
   output logic                         Overflow,
   output logic                         Done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = $clog2(SETTLE+1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   logic            first;
   logic [9:0]      last_num;
   logic [SW-1:0]   settle_cnt;

   logic [9:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   logic            is_new;
   logic            sample;
   logic            prime_hit;
   logic            full;
   logic            pop;
   logic            push;
   logic            drop;

   // A change that happened while in WAIT is still visible here because
   // only the current value is compared against the last one accepted.
   assign is_new    = first || (bus.NumberChecked != last_num);
   assign sample    = (state == S_WAIT) && (settle_cnt == SW'(1));
   assign prime_hit = sample && bus.Prime;
   assign full      = (Count == CW'(DEPTH));
   assign pop       = bus.RdReq && (Count != '0);
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push      = prime_hit && (!full || pop);
   assign drop      = prime_hit && full && !pop;

   // Head is read straight from storage; both terms come from registers.
   assign bus.RdValid = (Count != '0);
   assign bus.RdData  = (Count != '0) ? mem[rd_ptr] : 10'd0;

   always_ff @(posedge SysClk) begin
      if (push) begin
         mem[wr_ptr] <= last_num;
      end
   end

   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
         state      <= S_IDLE;
         first      <= 1'b1;
         last_num   <= 10'd0;
         settle_cnt <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         Count      <= '0;
         Total      <= 8'd0;
         Overflow   <= 1'b0;
         Done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_new) begin
                  last_num   <= bus.NumberChecked;
                  first      <= 1'b0;
                  settle_cnt <= SW'(SETTLE);
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               settle_cnt <= settle_cnt - SW'(1);
               if (sample) begin
                  if (last_num >= NumMax) begin
                     state <= S_DONE;
                     Done  <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (prime_hit && (Total != 8'hFF)) begin
            Total <= Total + 8'd1;
         end
         if (drop) begin
            Overflow <= 1'b1;
         end

         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   Count <= Count + CW'(1);
            2'b01:   Count <= Count - CW'(1);
            default: Count <= Count;
         endcase
      end
   end

endmodule
